// File: rtl/ddr_frame_reader.sv
// AXI read master: fetches one frame from DDR in bursts and pushes each beat into the display FIFO.
// Optional FRAME_READER_ERR_CNT_EN adds a saturating err_count output.
module ddr_frame_reader #(
  parameter int         CTRL_ADDR_WIDTH = 28,
  parameter int         MEM_DQ_WIDTH    = 32,
  parameter int         FRAME_BEATS     = 19200,
  parameter int         BURST_LEN       = 16,
  parameter int         BEAT_ADDR_INC   = 8,
  parameter logic [3:0] AXI_ID          = 4'd0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic [CTRL_ADDR_WIDTH-1:0]   frame_base,
  input  logic [5:0]                   fifo_space,
  output logic                         fifo_wr_en,
  output logic [MEM_DQ_WIDTH*8-1:0]    fifo_wr_data,
  output logic                         frame_busy,
  output logic                         frame_done,
  output logic                         rd_err,
`ifdef FRAME_READER_ERR_CNT_EN
  output logic [15:0]                  err_count,
`endif
  output logic [CTRL_ADDR_WIDTH-1:0]   axi_araddr,
  output logic [3:0]                   axi_arid,
  output logic [3:0]                   axi_arlen,
  output logic [2:0]                   axi_arsize,
  output logic [1:0]                   axi_arburst,
  output logic                         axi_arvalid,
  input  logic                         axi_arready,
  output logic                         axi_rready,
  input  logic [MEM_DQ_WIDTH*8-1:0]    axi_rdata,
  input  logic                         axi_rvalid,
  input  logic                         axi_rlast,
  input  logic [3:0]                   axi_rid
);
  localparam int             AW        = CTRL_ADDR_WIDTH;
  localparam int             DW        = MEM_DQ_WIDTH * 8;
  localparam logic [15:0]    FRAME_CNT = 16'(FRAME_BEATS);
  localparam logic [AW-1:0]  ADDR_INC  = AW'(BEAT_ADDR_INC);

  typedef enum logic [2:0] {IDLE, WAIT_SPACE, ADDR, DATA, FINISH} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   base_q, base_d;
  logic [15:0]     remaining_q, remaining_d;
  logic [4:0]      beat_cnt_q, beat_cnt_d;
  logic            rd_err_q, rd_err_d;
  logic            restart_q, restart_d;
  logic            last_err_q, last_err_d;
  logic            fifo_wr_en_q, fifo_wr_en_d;
  logic [DW-1:0]   fifo_wr_data_q, fifo_wr_data_d;

  logic [4:0]      len;
  logic            beat_ok, beat_bad, beat_last, rlast_bad;

  // Burst length is derived from the remaining count, so it is stable while in ADDR.
  assign len       = (remaining_q >= 16'(BURST_LEN)) ? 5'(BURST_LEN) : remaining_q[4:0];
  assign beat_ok   = (state_q == DATA) && axi_rvalid && (axi_rid == AXI_ID);
  assign beat_bad  = (state_q == DATA) && axi_rvalid && (axi_rid != AXI_ID);
  assign beat_last = beat_ok && (beat_cnt_q == (len - 5'd1));
  assign rlast_bad = beat_ok && (axi_rlast != beat_last);

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    base_d         = base_q;
    remaining_d    = remaining_q;
    beat_cnt_d     = beat_cnt_q;
    rd_err_d       = rd_err_q;
    restart_d      = restart_q;
    last_err_d     = last_err_q;
    fifo_wr_en_d   = 1'b0;
    fifo_wr_data_d = fifo_wr_data_q;

    if (frame_start) begin
      base_d   = frame_base;
      rd_err_d = 1'b0;
    end

    case (state_q)
      IDLE, FINISH: begin
        if (frame_start) begin
          addr_d      = frame_base;
          remaining_d = FRAME_CNT;
          state_d     = WAIT_SPACE;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_SPACE: begin
        // No burst in flight yet, so a new frame can be taken over directly.
        if (frame_start) begin
          addr_d      = frame_base;
          remaining_d = FRAME_CNT;
        end else if (fifo_space >= {1'b0, len}) begin
          beat_cnt_d = 5'd0;
          last_err_d = 1'b0;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (frame_start) restart_d = 1'b1;
        if (axi_arready) state_d = DATA;
      end
      DATA: begin
        if (frame_start) restart_d = 1'b1;
        if (beat_bad) rd_err_d = 1'b1;
        if (rlast_bad) begin
          rd_err_d   = 1'b1;
          last_err_d = 1'b1;
        end
        if (beat_ok) begin
          beat_cnt_d = beat_cnt_q + 5'd1;
          if (!restart_q) begin
            fifo_wr_en_d   = 1'b1;
            fifo_wr_data_d = axi_rdata;
          end
        end
        if (beat_last) begin
          if (restart_q || frame_start) begin
            addr_d      = base_d;
            remaining_d = FRAME_CNT;
            restart_d   = 1'b0;
            state_d     = WAIT_SPACE;
          end else begin
            addr_d      = addr_q + (AW'(len) * ADDR_INC);
            remaining_d = remaining_q - 16'(len);
            state_d     = (remaining_q == 16'(len)) ? FINISH : WAIT_SPACE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      base_q         <= '0;
      remaining_q    <= '0;
      beat_cnt_q     <= '0;
      rd_err_q       <= 1'b0;
      restart_q      <= 1'b0;
      last_err_q     <= 1'b0;
      fifo_wr_en_q   <= 1'b0;
      fifo_wr_data_q <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      base_q         <= base_d;
      remaining_q    <= remaining_d;
      beat_cnt_q     <= beat_cnt_d;
      rd_err_q       <= rd_err_d;
      restart_q      <= restart_d;
      last_err_q     <= last_err_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      fifo_wr_data_q <= fifo_wr_data_d;
    end
  end

`ifdef FRAME_READER_ERR_CNT_EN
  logic [15:0] err_count_q, err_count_d;
  logic        err_evt;

  // An rlast disagreement is counted once per burst, however many beats expose it.
  assign err_evt = beat_bad || (rlast_bad && !last_err_q);

  always_comb begin
    err_count_d = err_count_q;
    if (err_evt && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_wr_data = fifo_wr_data_q;
  assign frame_busy   = (state_q == WAIT_SPACE) || (state_q == ADDR) || (state_q == DATA);
  assign frame_done   = (state_q == FINISH);
  assign rd_err       = rd_err_q;
  assign axi_arvalid  = (state_q == ADDR);
  assign axi_araddr   = axi_arvalid ? addr_q : '0;
  assign axi_arlen    = axi_arvalid ? 4'(len - 5'd1) : 4'd0;
  assign axi_arid     = AXI_ID;
  assign axi_arsize   = 3'b101;
  assign axi_arburst  = 2'b01;
  assign axi_rready   = (state_q == DATA);
endmodule

// File: tb/tb_ddr_frame_reader.sv
// Scoreboarded bench for ddr_frame_reader: random AXI slave model, expected beat and AR queues.
module tb_ddr_frame_reader;
  localparam int AW  = 28;
  localparam int DW  = 256;
  localparam int FB  = 40;
  localparam int BL  = 16;
  localparam int INC = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          frame_start;
  logic [AW-1:0] frame_base;
  logic [5:0]    fifo_space;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          frame_busy, frame_done, rd_err;
`ifdef FRAME_READER_ERR_CNT_EN
  logic [15:0]   err_count;
`endif
  logic [AW-1:0] axi_araddr;
  logic [3:0]    axi_arid, axi_arlen;
  logic [2:0]    axi_arsize;
  logic [1:0]    axi_arburst;
  logic          axi_arvalid, axi_arready, axi_rready;
  logic [DW-1:0] axi_rdata;
  logic          axi_rvalid, axi_rlast;
  logic [3:0]    axi_rid;

  ddr_frame_reader #(
    .CTRL_ADDR_WIDTH(AW), .MEM_DQ_WIDTH(32), .FRAME_BEATS(FB),
    .BURST_LEN(BL), .BEAT_ADDR_INC(INC), .AXI_ID(4'd0)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_base(frame_base),
    .fifo_space(fifo_space), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .frame_busy(frame_busy), .frame_done(frame_done), .rd_err(rd_err),
`ifdef FRAME_READER_ERR_CNT_EN
    .err_count(err_count),
`endif
    .axi_araddr(axi_araddr), .axi_arid(axi_arid), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast), .axi_rid(axi_rid)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [31:0]   exp_ar_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            done_cnt = 0;
  int            push_cnt = 0;
  logic [31:0]   salt;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory contents as a pure function of the beat address.
  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    for (int k = 0; k < 8; k++) d[32*k +: 32] = ({4'h0, a} * 32'h9E3779B1) ^ salt ^ (32'(k) << 28);
    return d;
  endfunction

  task automatic expect_beats(input logic [AW-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(beat_data(base + AW'(i * INC)));
  endtask

  task automatic expect_ars(input logic [AW-1:0] base, input int nbeats);
    int rem;
    int off;
    rem = nbeats;
    off = 0;
    while (rem > 0) begin
      int n;
      n = (rem > BL) ? BL : rem;
      exp_ar_q.push_back({4'(n - 1), base + AW'(off * INC)});
      rem -= n;
      off += n;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && fifo_wr_en) begin
      push_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_push: got %0h expected no push", fifo_wr_data);
      end else begin
        check("push_data", fifo_wr_data, exp_q.pop_front());
      end
    end
    if (!rst && frame_done) done_cnt++;
  end

  // ---------------- AXI slave model ----------------
  int ar_stall   = 0;
  int burst_no   = 0;
  int inj_burst  = -1;
  int hook_burst = -1;
  int hook_beat  = 0;
  int hook_hits  = 0;
  int hook_acks  = 0;

  initial begin : slave_model
    logic [AW-1:0] a;
    logic [3:0]    l;
    bit            abort;
    bit            inj;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rlast   = 1'b0;
    axi_rid     = 4'd0;
    axi_rdata   = '0;
    forever begin
      @(negedge clk);
      if (rst || !axi_arvalid) continue;
      a = axi_araddr;
      l = axi_arlen;
      abort = 1'b0;
      if (exp_ar_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ar: got addr %0h len %0d", a, l);
      end else begin
        check("ar_addr_len", {l, a}, exp_ar_q.pop_front());
      end
      for (int s = 0; s < ar_stall && !abort; s++) begin
        @(negedge clk);
        if (rst) abort = 1'b1;
        else check("ar_hold", {axi_arvalid, axi_arlen, axi_araddr}, {1'b1, l, a});
      end
      if (!abort) begin
        axi_arready = 1'b1;
        @(negedge clk);
        axi_arready = 1'b0;
        if (rst) abort = 1'b1;
        else check("ar_drop", axi_arvalid, 1'b0);
      end
      burst_no++;
      inj = (burst_no == inj_burst);
      for (int k = 0; k <= int'(l) && !abort; k++) begin
        if (burst_no == hook_burst && k == hook_beat) begin
          axi_rvalid = 1'b0;
          hook_hits++;
          while (hook_acks < hook_hits) @(negedge clk);
        end
        if (inj && k == 4) begin
          axi_rvalid = 1'b1;
          axi_rid    = 4'd3;
          axi_rdata  = {8{32'hDEADBEEF}};
          axi_rlast  = 1'b0;
          @(negedge clk);
          if (rst) abort = 1'b1;
        end
        if (!abort && $urandom_range(0, 3) == 0) begin
          axi_rvalid = 1'b0;
          @(negedge clk);
          if (rst) abort = 1'b1;
        end
        if (!abort) begin
          axi_rvalid = 1'b1;
          axi_rid    = 4'd0;
          axi_rdata  = beat_data(a + AW'(k * INC));
          axi_rlast  = inj ? (k == 13) : (k == int'(l));
          @(negedge clk);
          if (rst) abort = 1'b1;
        end
      end
      axi_rvalid = 1'b0;
      axi_rlast  = 1'b0;
      axi_rid    = 4'd0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [AW-1:0] base);
    frame_base  = base;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_frame(input int target, input string name);
    int t;
    t = 0;
    while (done_cnt < target && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check({name, "_done_count"}, 256'(done_cnt), 256'(target));
    check({name, "_drained"}, 256'(exp_q.size() + exp_ar_q.size()), 256'(0));
    check({name, "_idle"}, frame_busy, 1'b0);
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_ctrl"}, {fifo_wr_en, frame_busy, frame_done, rd_err, axi_arvalid,
                            axi_rready, axi_araddr, axi_arlen}, '0);
    check({name, "_data"}, fifo_wr_data, '0);
    check({name, "_consts"}, {axi_arid, axi_arsize, axi_arburst}, {4'd0, 3'b101, 2'b01});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin : main_seq
    int            t;
    int            p0;
    logic [AW-1:0] b;
    salt        = $urandom;
    frame_start = 1'b0;
    frame_base  = '0;
    fifo_space  = 6'd63;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic three-burst frame.
    expect_beats(28'h100, FB);
    expect_ars(28'h100, FB);
    pulse_start(28'h100);
    check("busy_after_start", frame_busy, 1'b1);
    wait_frame(1, "basic");
    check("basic_rd_err", rd_err, 1'b0);

    // FIFO space stall.
    ar_stall   = $urandom_range(0, 2);
    b          = AW'($urandom);
    fifo_space = 6'd10;
    expect_beats(b, FB);
    expect_ars(b, FB);
    pulse_start(b);
    t = 0;
    for (int i = 0; i < 50; i++) begin
      if (axi_arvalid) t++;
      @(negedge clk);
    end
    check("stall_no_ar", 256'(t), 256'(0));
    fifo_space = 6'd63;
    t = 0;
    while (!axi_arvalid && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("stall_ar_latency_le2", 256'(t <= 2), 256'(1));
    wait_frame(2, "stall");

    // Long arready stall, base near the top of the address space to exercise wrap.
    ar_stall = 20;
    expect_beats(28'hFFFFF40, FB);
    expect_ars(28'hFFFFF40, FB);
    pulse_start(28'hFFFFF40);
    wait_frame(3, "arstall");
    ar_stall = $urandom_range(0, 2);

    // Restart mid burst 2: five beats pushed, rest of the burst drained silently.
    hook_burst = burst_no + 2;
    hook_beat  = 5;
    expect_beats(28'h100, BL + 5);
    expect_ars(28'h100, 2 * BL);
    expect_beats(28'h4000, FB);
    expect_ars(28'h4000, FB);
    pulse_start(28'h100);
    t = 0;
    while (hook_hits == 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("restart_hook_reached", 256'(hook_hits), 256'(1));
    pulse_start(28'h4000);
    hook_acks++;
    check("restart_busy", frame_busy, 1'b1);
    wait_frame(4, "restart");

    // Foreign-ID beat plus early rlast in the first burst.
    inj_burst = burst_no + 1;
    b = AW'($urandom) & ~AW'(7);
    expect_beats(b, FB);
    expect_ars(b, FB);
    pulse_start(b);
    wait_frame(5, "err");
    check("err_rd_err", rd_err, 1'b1);
`ifdef FRAME_READER_ERR_CNT_EN
    check("err_count", err_count, 16'd2);
`endif

    // Back-to-back: second start lands in the FINISH cycle of the first.
    b = AW'($urandom);
    expect_beats(b, FB);
    expect_ars(b, FB);
    pulse_start(b);
    check("rd_err_cleared", rd_err, 1'b0);
    expect_beats(28'h0AB000, FB);
    expect_ars(28'h0AB000, FB);
    t = 0;
    while (!frame_done && t < 4000) begin
      @(negedge clk);
      t++;
    end
    pulse_start(28'h0AB000);
    check("b2b_busy", frame_busy, 1'b1);
    wait_frame(7, "b2b");
    check("b2b_rd_err", rd_err, 1'b0);

    // Asynchronous reset in the middle of burst 2.
    expect_beats(28'h100, FB);
    expect_ars(28'h100, FB);
    p0 = push_cnt;
    pulse_start(28'h100);
    t = 0;
    while (push_cnt < p0 + 20 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    #2;
    rst = 1'b1;
    #1;
    check_reset_outs("midreset");
    exp_q.delete();
    exp_ar_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after_reset_idle", {frame_busy, rd_err}, 2'b00);
    expect_beats(28'h100, FB);
    expect_ars(28'h100, FB);
    pulse_start(28'h100);
    wait_frame(8, "postreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ddr_frame_reader.md
Name: ddr_frame_reader

Overview:
AXI read master that fetches one stored video frame from DDR and streams it, one 256-bit beat per write, into the display-side read buffer FIFO. It is the read-direction counterpart of the write interconnect that stores sampled video frames. It sits between the DDR controller AXI read channels and the display buffer write port, all in the DDR user clock domain. It is started once per output frame by a synchronised frame-sync pulse.

Parameters:
CTRL_ADDR_WIDTH, 28, AXI address width (row+bank+column).
MEM_DQ_WIDTH, 32, DDR DQ width; AXI data width = MEM_DQ_WIDTH*8.
FRAME_BEATS, 19200, beats per frame (1-65535).
BURST_LEN, 16, maximum beats per burst (1-16).
BEAT_ADDR_INC, 8, address increment per beat (column units).
AXI_ID, 4'd0, ID driven on axi_arid and expected on axi_rid.

Ports:
clk  in  1  DDR user clock
rst  in  1  asynchronous active-high reset
frame_start  in  1  single-cycle pulse: start reading a frame
frame_base  in  CTRL_ADDR_WIDTH  frame base address, latched on frame_start
fifo_space  in  6  free entries in the downstream FIFO (saturating)
fifo_wr_en  out  1  downstream FIFO write strobe
fifo_wr_data  out  MEM_DQ_WIDTH*8  beat data
frame_busy  out  1  high from the accepted frame_start until the last beat is pushed
frame_done  out  1  one-cycle pulse after the last beat of a frame is pushed
rd_err  out  1  sticky error flag; cleared by frame_start
axi_araddr  out  CTRL_ADDR_WIDTH  burst address
axi_arid  out  4  = AXI_ID
axi_arlen  out  4  beats-1
axi_arsize  out  3  constant 3'b101 (32 bytes)
axi_arburst  out  2  constant 2'b01 (INCR)
axi_arvalid  out  1  address valid
axi_arready  in  1  address accepted
axi_rready  out  1  data ready
axi_rdata  in  MEM_DQ_WIDTH*8  read data
axi_rvalid  in  1  data valid
axi_rlast  in  1  last beat of burst
axi_rid  in  4  read ID

Behaviour:
- Reset: all outputs 0 except axi_arid, axi_arsize and axi_arburst, which hold their constants. FSM goes to IDLE; counters clear. Reset mid-burst abandons the burst without waiting for the slave.
- FSM states: IDLE, WAIT_SPACE, ADDR, DATA, FINISH. At most one burst outstanding.
- IDLE: on frame_start, latch frame_base into the address register, load remaining=FRAME_BEATS, clear rd_err, set frame_busy, go to WAIT_SPACE.
- Burst length: len = min(BURST_LEN, remaining). axi_arlen = len-1. A final short burst is allowed.
- WAIT_SPACE: when fifo_space >= len, go to ADDR next cycle. This guarantees the FIFO never overflows.
- ADDR: assert axi_arvalid with stable araddr/arlen until the cycle in which axi_arready=1; then deassert and go to DATA.
- DATA: axi_rready=1 throughout.
  - Each rvalid beat with rid==AXI_ID: fifo_wr_en=1 with fifo_wr_data=rdata, registered, 1-cycle latency.
  - Beat with rid!=AXI_ID: not pushed, not counted, rd_err set.
  - The burst ends on the len-th counted beat. If rlast disagrees with the beat count (early or missing), set rd_err. The counter is authoritative.
- End of burst: address += len*BEAT_ADDR_INC (wraps modulo 2^CTRL_ADDR_WIDTH); remaining -= len. If remaining>0 go to WAIT_SPACE, else go to FINISH.
- FINISH: one cycle. frame_done=1, frame_busy=0, then IDLE.
- frame_start while busy:
  - Latch the new base and set restart_pending.
  - During ADDR, the address handshake still completes.
  - The current burst drains with fifo_wr_en suppressed.
  - Then restart from the new base with remaining=FRAME_BEATS.
  - No frame_done is issued for the aborted frame; frame_busy stays high.
- frame_start in the same cycle as FINISH is accepted as a new frame; frame_done still pulses.
- Throughput: there is no idle cycle between the ADDR handshake and accepting data.

Optional Feature:
Macro FRAME_READER_ERR_CNT_EN.
- Defined: adds output err_count [15:0]. It increments, saturating at 16'hFFFF, on each rid-mismatch beat and each rlast mismatch. It resets only on rst.
- Undefined: the port and counter are absent; rd_err behaviour is unchanged.

Test Plan:
- FRAME_BEATS=40, BURST_LEN=16, base=0x100, fifo_space=63 -> three bursts: arlen 15,15,7; araddr 0x100,0x180,0x200. 40 fifo_wr_en pulses in order; frame_done once; rd_err=0.
- fifo_space=10 for 50 cycles, then 63 -> no arvalid during the stall; first AR appears within 2 cycles of space>=16.
- arready held low 20 cycles -> araddr/arlen stable throughout; arvalid drops the cycle after the handshake.
- Second frame_start at beat 5 of burst 2 with base=0x4000 -> remaining 11 beats of that burst not pushed; next AR at 0x4000 arlen 15; single frame_done after 40 new beats.
- Inject one beat with rid=4'd3 and rlast on beat 14 of 16 -> mismatched beat dropped; 16 valid beats pushed; rd_err=1; err_count=2 when the macro is defined.
- rst asserted mid-DATA -> all outputs 0 asynchronously; after release, the next frame_start gives a normal 3-burst frame.
